// File: rtl/io_key_sw_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_key_sw_responder
// Brief    : Memory-mapped responder for the board KEY and SW inputs.
//            Synchronises the raw inputs, debounces the switches and exposes
//            a DATA register plus a CTRL/STATUS register (Ready, Overrun, IE)
//            per device. Read data and hit are combinational so the MEM
//            stage can mux them ahead of the data memory.
// Revision : 1.0 - initial release
// ============================================================================
module io_key_sw_responder #(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = 4,
    parameter int               SWBITS          = 10,
    parameter logic [DBITS-1:0] ADDRKDATA       = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSDATA       = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hFFFFF094,
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] key_n,
    input  logic [SWBITS-1:0]  sw,
    input  logic [DBITS-1:0]   addr,
    input  logic               re,
    input  logic               we,
    input  logic [DBITS-1:0]   wdata,
    output logic [DBITS-1:0]   rdata,
    output logic               hit,
    output logic               intr
);

    // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int                CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // CTRL register bit positions.
    localparam int C_BIT_READY   = 0;
    localparam int C_BIT_OVERRUN = 2;
    localparam int C_BIT_IE      = 8;

    // ------------------------------------------------------------------
    // Synchroniser, data and debounce state
    // ------------------------------------------------------------------
    logic [KEYBITS-1:0] r_key_sync1;
    logic [KEYBITS-1:0] r_key_sync2;
    logic [SWBITS-1:0]  r_sw_sync1;
    logic [SWBITS-1:0]  r_sw_sync2;
    logic [KEYBITS-1:0] r_kdata;
    logic [SWBITS-1:0]  r_sdata;
    logic [SWBITS-1:0]  r_sw_cand;
    logic [CNT_W-1:0]   r_sw_cnt;

    // Per-device status flags
    logic r_k_ready;
    logic r_k_overrun;
    logic r_k_ie;
    logic r_s_ready;
    logic r_s_overrun;
    logic r_s_ie;
    logic r_intr;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [KEYBITS-1:0] w_key_s;
    logic               w_k_event;
    logic               w_s_event;
    logic               w_hit_kdata;
    logic               w_hit_kctrl;
    logic               w_hit_sdata;
    logic               w_hit_sctrl;
    logic               w_k_rd_clr;
    logic               w_s_rd_clr;
    logic               w_k_ctrl_wr;
    logic               w_s_ctrl_wr;
    logic [DBITS-1:0]   w_kctrl;
    logic [DBITS-1:0]   w_sctrl;
    logic               w_unused_wdata;

    // Keys are active-low on the board; present them as pressed = 1.
    assign w_key_s   = ~r_key_sync2;
    assign w_k_event = (w_key_s != r_kdata);

    // A switch event is the edge on which a fully settled candidate differs
    // from the published value.
    assign w_s_event = (r_sw_sync2 == r_sw_cand) && (r_sw_cnt == C_CNT_MAX) &&
                       (r_sw_cand != r_sdata);

    assign w_hit_kdata = (addr == ADDRKDATA);
    assign w_hit_kctrl = (addr == ADDRKCTRL);
    assign w_hit_sdata = (addr == ADDRSDATA);
    assign w_hit_sctrl = (addr == ADDRSCTRL);

    // Reading a DATA register consumes the Ready flag.
    assign w_k_rd_clr  = re && w_hit_kdata;
    assign w_s_rd_clr  = re && w_hit_sdata;
    assign w_k_ctrl_wr = we && w_hit_kctrl;
    assign w_s_ctrl_wr = we && w_hit_sctrl;

    // Only wdata bits 2 and 8 carry meaning for CTRL writes.
    assign w_unused_wdata = ^{wdata[DBITS-1:C_BIT_IE+1], wdata[C_BIT_IE-1:C_BIT_OVERRUN+1],
                              wdata[C_BIT_OVERRUN-1:0]};

    // ------------------------------------------------------------------
    // Two-flop synchronisers; keys idle high, switches idle low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_sync1 <= '1;
            r_key_sync2 <= '1;
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
        end else begin
            r_key_sync1 <= key_n;
            r_key_sync2 <= r_key_sync1;
            r_sw_sync1  <= sw;
            r_sw_sync2  <= r_sw_sync1;
        end
    end

    // KEY data register tracks the synchronised keys every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kdata <= '0;
        end else begin
            r_kdata <= w_key_s;
        end
    end

    // Switch debounce: any change restarts the count; publish once settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_cand <= '0;
            r_sw_cnt  <= '0;
            r_sdata   <= '0;
        end else if (r_sw_sync2 != r_sw_cand) begin
            r_sw_cand <= r_sw_sync2;
            r_sw_cnt  <= '0;
        end else if (r_sw_cnt != C_CNT_MAX) begin
            r_sw_cnt  <= r_sw_cnt + 1'b1;
        end else if (r_sw_cand != r_sdata) begin
            r_sdata   <= r_sw_cand;
        end
    end

    // KEY status flags: event beats a same-edge read, overrun set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k_ready   <= 1'b0;
            r_k_overrun <= 1'b0;
            r_k_ie      <= 1'b0;
        end else begin
            if (w_k_event) begin
                r_k_ready <= 1'b1;
            end else if (w_k_rd_clr) begin
                r_k_ready <= 1'b0;
            end

            if (w_k_event && r_k_ready && !w_k_rd_clr) begin
                r_k_overrun <= 1'b1;
            end else if (w_k_ctrl_wr && !wdata[C_BIT_OVERRUN]) begin
                r_k_overrun <= 1'b0;
            end

            if (w_k_ctrl_wr) begin
                r_k_ie <= wdata[C_BIT_IE];
            end
        end
    end

    // SW status flags: same rules as the KEY device.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ready   <= 1'b0;
            r_s_overrun <= 1'b0;
            r_s_ie      <= 1'b0;
        end else begin
            if (w_s_event) begin
                r_s_ready <= 1'b1;
            end else if (w_s_rd_clr) begin
                r_s_ready <= 1'b0;
            end

            if (w_s_event && r_s_ready && !w_s_rd_clr) begin
                r_s_overrun <= 1'b1;
            end else if (w_s_ctrl_wr && !wdata[C_BIT_OVERRUN]) begin
                r_s_overrun <= 1'b0;
            end

            if (w_s_ctrl_wr) begin
                r_s_ie <= wdata[C_BIT_IE];
            end
        end
    end

    // Interrupt is a registered OR of enabled Ready flags (one cycle behind).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= (r_k_ready & r_k_ie) | (r_s_ready & r_s_ie);
        end
    end

    // Assemble the CTRL/STATUS read images.
    always_comb begin
        w_kctrl                = '0;
        w_kctrl[C_BIT_READY]   = r_k_ready;
        w_kctrl[C_BIT_OVERRUN] = r_k_overrun;
        w_kctrl[C_BIT_IE]      = r_k_ie;
        w_sctrl                = '0;
        w_sctrl[C_BIT_READY]   = r_s_ready;
        w_sctrl[C_BIT_OVERRUN] = r_s_overrun;
        w_sctrl[C_BIT_IE]      = r_s_ie;
    end

    // Read mux: independent of re so the MEM stage can select it freely.
    always_comb begin
        rdata = '0;
        if (w_hit_kdata) begin
            rdata = {{(DBITS-KEYBITS){1'b0}}, r_kdata};
        end else if (w_hit_kctrl) begin
            rdata = w_kctrl;
        end else if (w_hit_sdata) begin
            rdata = {{(DBITS-SWBITS){1'b0}}, r_sdata};
        end else if (w_hit_sctrl) begin
            rdata = w_sctrl;
        end
    end

    assign hit  = w_hit_kdata | w_hit_kctrl | w_hit_sdata | w_hit_sctrl;
    assign intr = r_intr;

endmodule
`default_nettype wire

// File: doc/io_key_sw_responder.md
Name: io_key_sw_responder

Overview:
- Memory-mapped bus responder for the board's KEY and SW inputs. It is the device side of the CPU's MEM-stage load/store path.
- Synchronises the raw inputs and debounces the switches.
- Exposes a data register and a control/status register per device: sticky Ready and Overrun flags, plus an interrupt-enable bit.
- Drives a combinational read-data/hit result that the MEM stage muxes ahead of D-MEM.

Parameters:
DBITS, 32, bus data/address width
KEYBITS, 4, number of push keys
SWBITS, 10, number of slide switches
ADDRKDATA, 32'hFFFFF080, KEY data register address
ADDRKCTRL, 32'hFFFFF084, KEY control/status address
ADDRSDATA, 32'hFFFFF090, SW data register address
ADDRSCTRL, 32'hFFFFF094, SW control/status address
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before SDATA updates (>=2); counter width = clog2(DEBOUNCE_CYCLES)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
key_n  input  KEYBITS  raw keys, active-low (pressed = 0)
sw  input  SWBITS  raw switches
addr  input  DBITS  bus address from MEM stage
re  input  1  read strobe (load in MEM)
we  input  1  write strobe (store in MEM)
wdata  input  DBITS  store data
rdata  output  DBITS  read data, combinational, 0 when no hit
hit  output  1  combinational, 1 when addr equals any of the four addresses (independent of re/we)
intr  output  1  interrupt request

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - key_n synchroniser flops all 1.
  - sw synchroniser flops 0; KDATA 0; SDATA 0.
  - Debounce candidate 0; debounce counter 0.
  - All Ready, Overrun and IE bits 0; intr 0.
- Synchronisers:
  - Two-flop synchroniser on key_n and on sw. key_s = ~key_n_sync2.
- KEY path:
  - KDATA <= key_s every edge.
  - KEY event = (key_s != KDATA) at that edge.
  - Raw change to KDATA update latency is 3 edges.
- SW debounce:
  - Candidate register plus saturating counter.
  - On an edge where sw_sync2 != candidate: candidate <= sw_sync2 and cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt++.
  - Else (cnt == DEBOUNCE_CYCLES-1) and candidate != SDATA: SDATA <= candidate, and this is an SW event.
  - Net latency: SDATA changes on the (DEBOUNCE_CYCLES+3)th rising edge after a raw change held stable.
  - Any glitch restarts the count.
  - After reset release with switches up, SDATA follows after the same latency and raises SW Ready.
- CTRL register layout (KCTRL and SCTRL identical):
  - bit0 Ready: read-only.
  - bit2 Overrun: write-0-to-clear, writing 1 has no effect.
  - bit8 IE: read/write.
  - All other bits read 0.
- Ready:
  - Set on the device's event.
  - Cleared on an edge with re=1 and addr == that device's DATA address.
  - Event and clearing read on the same edge: Ready stays 1, Overrun unchanged.
- Overrun:
  - Set on an event when Ready=1 and no clearing read occurs on that edge.
  - Event and an Overrun-clear write on the same edge: Overrun = 1 (set wins).
- Writes:
  - Writes to DATA addresses are ignored.
  - Writes to CTRL update IE = wdata[8]; if wdata[2]==0, clear Overrun (subject to the set-wins rule).
  - re and we together are legal; both effects apply.
  - re=0 has no side effect, even on a hit.
- rdata:
  - KDATA address: zero-extended KDATA. SDATA address: zero-extended SDATA.
  - CTRL addresses: {23'b0, IE, 5'b0, Overrun, 1'b0, Ready}.
  - Any other address: 0. rdata is independent of re.
- intr: registered; intr <= (KReady & KIE) | (SReady & SIE), so it lags the flags by one cycle.
- Reset mid-debounce or mid-event: everything returns to reset values immediately; no event is generated on release.

Test Plan:
- Reset with key_n=4'hF, sw=0 -> rdata=0 at all four addresses, intr=0, hit=1 only at the four addresses (e.g. 0xFFFFF088 gives hit=0).
- key_n 1111->1110 -> KDATA=1 three edges later; KCTRL reads 0x1; load of ADDRKDATA reads 0x1 and KCTRL reads 0x0 on the next cycle.
- Two key changes with no intervening KDATA read -> KCTRL=0x5. Store 0x0 to KCTRL -> 0x1. Store 0x4 -> Overrun unchanged.
- DEBOUNCE_CYCLES=4, sw 0->0x2A0 held -> SDATA=0x2A0 on the 7th edge, not earlier. Repeat with a 1-cycle glitch mid-count -> the count restarts.
- Store 0x100 to SCTRL, then an SW event -> intr=1 one cycle after Ready. SDATA read -> Ready 0, then intr 0 the following cycle.
- KEY event on the same edge as a KDATA load -> Ready stays 1, Overrun 0. Assert reset mid-debounce -> all outputs 0, and no event after release until inputs are stable again.
